// File: rtl/branch_predictor_table_if.sv
// Fetch/execute-side interface of the branch predictor table: lookup request,
// registered prediction and resolved-branch training port.
interface branch_predictor_table_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic [XLEN-1:0] update_target;
  logic            update_taken;
  logic            update_is_branch;
  logic            update_is_jump;

  modport master (
    output fetch_valid, fetch_pc,
    output update_valid, update_pc, update_target, update_taken,
    output update_is_branch, update_is_jump,
    input  pred_valid, pred_taken, pred_target
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  update_valid, update_pc, update_target, update_taken,
    input  update_is_branch, update_is_jump,
    output pred_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor_table.sv
// Direct-mapped saturating-counter predictor with tagged BTB, 1-cycle lookup.
// Optional gshare counter indexing is enabled by defining BPU_GSHARE_EN.
module branch_predictor_table #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CNT_BITS = 2,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned GHR_BITS = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_predictor_table_if.slave bus
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [CNT_BITS-1:0] cnt_t;
  typedef logic [XLEN-1:0]     addr_t;

  // Elaboration-time parameter sanity
  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0 || CNT_BITS < 2 ||
      GHR_BITS > IDX_BITS || XLEN < IDX_BITS + 2 + TAG_BITS) begin : g_param_check
    $error("branch_predictor_table: illegal parameter combination");
  end

  logic  valid_q  [ENTRIES];
  logic  jump_q   [ENTRIES];
  tag_t  tag_q    [ENTRIES];
  addr_t target_q [ENTRIES];
  cnt_t  cnt_q    [ENTRIES];

  logic  pred_valid_q;
  logic  pred_taken_q;
  addr_t pred_target_q;

  idx_t  l_idx;
  idx_t  l_cidx;
  tag_t  l_tag;
  logic  l_hit;
  logic  l_taken;
  addr_t l_target;

  idx_t  u_idx;
  idx_t  u_cidx;
  tag_t  u_tag;
  logic  u_hit;
  logic  do_jump;
  logic  do_br;
  logic  do_br_hit;
  logic  do_alloc;
  logic  entry_wr;
  logic  target_wr;
  logic  cnt_wr;
  cnt_t  cnt_cur;
  cnt_t  cnt_nxt;

  // Only the index/tag fields of the update PC matter; the rest is don't-care
  logic unused_update_pc;
  assign unused_update_pc = ^bus.update_pc;

  assign l_idx = bus.fetch_pc[IDX_BITS+1:2];
  assign l_tag = bus.fetch_pc[IDX_BITS+2 +: TAG_BITS];
  assign u_idx = bus.update_pc[IDX_BITS+1:2];
  assign u_tag = bus.update_pc[IDX_BITS+2 +: TAG_BITS];

`ifdef BPU_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  // Counters see PC index folded with global history; update uses pre-shift GHR
  assign l_cidx = l_idx ^ IDX_BITS'(ghr_q);
  assign u_cidx = u_idx ^ IDX_BITS'(ghr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (do_br) begin
      ghr_q <= GHR_BITS'({ghr_q, bus.update_taken});
    end
  end
`else
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  // Lookup against the pre-update table contents (read-before-write)
  always_comb begin
    l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    l_taken  = l_hit && (jump_q[l_idx] || cnt_q[l_cidx][CNT_BITS-1]);
    l_target = l_taken ? target_q[l_idx] : bus.fetch_pc + XLEN'(4);
  end

  // Training decode: jump wins over branch; not-taken misses leave the table alone
  always_comb begin
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    do_jump   = bus.update_valid && bus.update_is_jump;
    do_br     = bus.update_valid && bus.update_is_branch && !bus.update_is_jump;
    do_br_hit = do_br && u_hit;
    do_alloc  = do_br && !u_hit && bus.update_taken;
    entry_wr  = do_jump || do_alloc;
    target_wr = do_jump || (do_br && bus.update_taken);
    cnt_wr    = do_jump || do_br_hit || do_alloc;
  end

  // Next counter value with saturation at both ends
  always_comb begin
    cnt_cur = cnt_q[u_cidx];
    cnt_nxt = cnt_cur;
    if (do_jump) begin
      cnt_nxt = CNT_MAX;
    end else if (do_alloc) begin
      cnt_nxt = CNT_WT;
    end else if (do_br_hit) begin
      if (bus.update_taken && cnt_cur != CNT_MAX) begin
        cnt_nxt = cnt_cur + CNT_BITS'(1);
      end else if (!bus.update_taken && cnt_cur != '0) begin
        cnt_nxt = cnt_cur - CNT_BITS'(1);
      end
    end
  end

  // Reset-cleared per-entry state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[IDX_BITS'(i)] <= 1'b0;
        jump_q[IDX_BITS'(i)]  <= 1'b0;
        cnt_q[IDX_BITS'(i)]   <= CNT_WNT;
      end
    end else begin
      if (entry_wr) begin
        valid_q[u_idx] <= 1'b1;
      end
      if (do_jump) begin
        jump_q[u_idx] <= 1'b1;
      end else if (do_br_hit || do_alloc) begin
        jump_q[u_idx] <= 1'b0;
      end
      if (cnt_wr) begin
        cnt_q[u_cidx] <= cnt_nxt;
      end
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (entry_wr) begin
      tag_q[u_idx] <= u_tag;
    end
    if (target_wr) begin
      target_q[u_idx] <= bus.update_target;
    end
  end

  // Registered prediction; target holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q <= bus.fetch_valid;
      pred_taken_q <= bus.fetch_valid && l_taken;
      if (bus.fetch_valid) begin
        pred_target_q <= l_target;
      end
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench for branch_predictor_table: directed test-plan sequences plus
// random traffic checked against an independent behavioural model.
module tb_branch_predictor_table;

  localparam int unsigned XL = 32;
  localparam int unsigned ENT = 16;
  localparam int unsigned TB = 8;
  localparam int unsigned GB = 4;
`ifdef BPU_GSHARE_EN
  localparam bit DIR = 1'b0;
`else
  localparam bit DIR = 1'b1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_predictor_table_if #(.XLEN(XL)) bus ();

  branch_predictor_table #(
    .XLEN(XL), .ENTRIES(ENT), .CNT_BITS(2), .TAG_BITS(TB), .GHR_BITS(GB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        t;
    logic [31:0] tgt;
    string       tag;
  } exp_t;
  exp_t sb[$];

  // Behavioural reference state
  bit       m_valid[16];
  bit       m_jump[16];
  bit [7:0] m_tag[16];
  bit [31:0] m_tgt[16];
  int       m_cnt[16];
  bit [3:0] m_ghr;
  bit [31:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit [3:0] m_cidx(input bit [3:0] i);
`ifdef BPU_GSHARE_EN
    return i ^ m_ghr;
`else
    return i;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_jump[i]  = 1'b0;
      m_cnt[i]   = 1;
    end
    m_ghr  = '0;
    m_last = '0;
  endtask

  task automatic model_update(input bit [31:0] pc, input bit [31:0] tgt, input bit t,
                              input bit br, input bit jp);
    bit [3:0] i;
    bit [3:0] ci;
    bit       hit;
    i   = pc[5:2];
    ci  = m_cidx(i);
    hit = m_valid[i] && (m_tag[i] == pc[13:6]);
    if (jp) begin
      m_valid[i] = 1'b1; m_jump[i] = 1'b1; m_tag[i] = pc[13:6]; m_tgt[i] = tgt;
      m_cnt[ci] = 3;
    end else if (br) begin
      if (hit) begin
        if (t) m_cnt[ci] = (m_cnt[ci] < 3) ? m_cnt[ci] + 1 : 3;
        else   m_cnt[ci] = (m_cnt[ci] > 0) ? m_cnt[ci] - 1 : 0;
        if (t) m_tgt[i] = tgt;
        m_jump[i] = 1'b0;
      end else if (t) begin
        m_valid[i] = 1'b1; m_jump[i] = 1'b0; m_tag[i] = pc[13:6]; m_tgt[i] = tgt;
        m_cnt[ci] = 2;
      end
      m_ghr = {m_ghr[2:0], t};
    end
  endtask

  // One cycle: drive both ports, push the expected prediction, check it next edge
  task automatic step(input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic ubr, input logic ujp,
                      input logic use_dir, input logic dt, input logic [31:0] dtgt,
                      input string tag);
    exp_t e;
    exp_t g;
    bit [3:0] i;
    bit       hit;
    bus.fetch_valid      = fv;
    bus.fetch_pc         = fpc;
    bus.update_valid     = uv;
    bus.update_pc        = upc;
    bus.update_target    = utgt;
    bus.update_taken     = ut;
    bus.update_is_branch = ubr;
    bus.update_is_jump   = ujp;
    i   = fpc[5:2];
    hit = m_valid[i] && (m_tag[i] == fpc[13:6]);
    e.tag = tag;
    e.v   = fv;
    if (fv) begin
      e.t   = hit && (m_jump[i] || m_cnt[m_cidx(i)] >= 2);
      e.tgt = e.t ? m_tgt[i] : fpc + 32'd4;
      if (use_dir) begin
        e.t   = dt;
        e.tgt = dtgt;
      end
      m_last = e.tgt;
    end else begin
      e.t   = 1'b0;
      e.tgt = m_last;
    end
    sb.push_back(e);
    if (uv) model_update(upc, utgt, ut, ubr, ujp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty got 0x%0h expected 0x1", tag, sb.size());
    end else begin
      g = sb.pop_front();
      check({g.tag, "_valid"},  {31'd0, bus.pred_valid}, {31'd0, g.v});
      check({g.tag, "_taken"},  {31'd0, bus.pred_taken}, {31'd0, g.t});
      check({g.tag, "_target"}, bus.pred_target, g.tgt);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic use_dir, input logic dt,
                        input logic [31:0] dtgt, input string tag);
    step(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, use_dir, dt, dtgt, tag);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic t,
                     input logic br, input logic jp);
    step(1'b0, 32'h0, 1'b1, pc, tgt, t, br, jp, 1'b0, 1'b0, 32'h0, "upd");
  endtask

  task automatic idle_inputs();
    bus.fetch_valid = 1'b0; bus.fetch_pc = '0;
    bus.update_valid = 1'b0; bus.update_pc = '0; bus.update_target = '0;
    bus.update_taken = 1'b0; bus.update_is_branch = 1'b0; bus.update_is_jump = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check({tag, "_rst_valid"},  {31'd0, bus.pred_valid}, 32'd0);
    check({tag, "_rst_taken"},  {31'd0, bus.pred_taken}, 32'd0);
    check({tag, "_rst_target"}, bus.pred_target, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool[8];
    logic        v;
    logic [31:0] p;
    logic [31:0] q;
    pool = '{32'h100, 32'h1100, 32'h200, 32'h300, 32'h10, 32'h14, 32'h40, 32'h2240};
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    do_reset("init");

    lookup(32'h100, 1'b1, 1'b0, 32'h104, "cold_lookup");
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "idle_hold");

    upd(32'h200, 32'h80, 1'b1, 1'b0, 1'b1);
    lookup(32'h200, DIR, 1'b1, 32'h80, "jump_hit");

    upd(32'h100, 32'h40, 1'b1, 1'b1, 1'b0);
    lookup(32'h100, DIR, 1'b1, 32'h40, "br_alloc");
    upd(32'h100, 32'h40, 1'b0, 1'b1, 1'b0);
    lookup(32'h100, DIR, 1'b0, 32'h104, "br_nt");

    for (int k = 0; k < 3; k++) upd(32'h100, 32'h40, 1'b1, 1'b1, 1'b0);
    lookup(32'h100, DIR, 1'b1, 32'h40, "sat_hi");
    upd(32'h100, 32'h40, 1'b0, 1'b1, 1'b0);
    lookup(32'h100, DIR, 1'b1, 32'h40, "sat_nt1");
    upd(32'h100, 32'h40, 1'b0, 1'b1, 1'b0);
    lookup(32'h100, DIR, 1'b0, 32'h104, "sat_nt2");

    upd(32'h100, 32'h40, 1'b1, 1'b1, 1'b0);
    lookup(32'h1100, DIR, 1'b0, 32'h1104, "tag_alias");

    step(1'b1, 32'h300, 1'b1, 32'h300, 32'h500, 1'b1, 1'b1, 1'b0,
         DIR, 1'b0, 32'h304, "rbw_same");
    lookup(32'h300, DIR, 1'b1, 32'h500, "rbw_next");

    // Async reset asserted in the middle of an update cycle
    bus.update_valid = 1'b1; bus.update_pc = 32'h200; bus.update_target = 32'h80;
    bus.update_is_jump = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus.pred_valid}, 32'd0);
    check("midrst_target", bus.pred_target, 32'd0);
    do_reset("midrst");
    lookup(32'h200, 1'b1, 1'b0, 32'h204, "midrst_miss");

    do_reset("ghr");
    for (int k = 0; k < 4; k++) upd(32'h10, 32'h900, 1'b1, 1'b1, 1'b0);
`ifdef BPU_GSHARE_EN
    lookup(32'h10, 1'b1, 1'b0, 32'h14, "ghr_lookup");
`else
    lookup(32'h10, 1'b1, 1'b1, 32'h900, "ghr_lookup");
`endif

    lookup(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, "pc_wrap");

    for (int k = 0; k < 400; k++) begin
      v = 1'($urandom_range(0, 3) != 0);
      p = pool[$urandom_range(0, 7)];
      q = pool[$urandom_range(0, 7)];
      step(v, p, 1'($urandom_range(0, 1)), q, {$urandom_range(0, 255), 2'b00},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), 1'b0, 1'b0, 32'h0, "rand");
    end

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
